button_pulse_gen: RTL and testbench
===================================

// Module: button_pulse_gen
// PURPOSE
//   Producer side of the single-cycle pulse interface consumed by the LED stretchers and controller logic.
//   Takes one raw, asynchronous, active-low pushbutton and synchronizes and debounces it.
//   Emits exactly one 1-clk pulse per accepted press, plus optional auto-repeat pulses while the button is held.
//   Instantiated once per board button. Its pulse_out feeds controller_output[i] and the led stretchers.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000   consecutive stable samples needed to accept a press or a release (20 ms @ 50 MHz); >=2
//   REPEAT_DELAY     25_000_000  cycles from the accepted press to the first auto-repeat pulse (0.5 s); >=2
//   REPEAT_PERIOD    5_000_000   cycles between subsequent auto-repeat pulses (0.1 s); >=2
// PORTS
//   clk          in   1  system clock, 50 MHz
//   reset_fixed  in   1  reset, asynchronous, active-low
//   btn_n        in   1  raw pushbutton, active-low (0 = pressed), asynchronous to clk
//   repeat_en    in   1  1 = auto-repeat enabled while held
//   pulse_out    out  1  1-clk pulse per accepted press or repeat tick
//   btn_level    out  1  debounced button state (1 = pressed)
// BEHAVIOUR
// - Synchronizer: 2-FF chain on btn_n, both flops reset to 1 (released). pressed_s = ~sync2.
//   All FSM decisions use pressed_s only.
// - Counter: one shared counter, width $clog2(max of the 3 params)+1, reset 0. It never wraps; it is cleared on every state change.
// - Reset values: pulse_out=0, btn_level=0, state=IDLE, cnt=0. Reset may occur in any state and aborts it immediately.
// - FSM (all outputs registered):
//   IDLE:     btn_level=0.
//             pressed_s=1 -> PRESS_DB, cnt=1.
//   PRESS_DB: pressed_s=0 -> IDLE, cnt=0 (bounce rejected, no pulse).
//             Else if cnt==DEBOUNCE_CYCLES-1 -> HOLD, cnt=0, pulse_out=1 for 1 cycle, btn_level=1.
//             Else cnt++.
//   HOLD:     pressed_s=0 -> REL_DB, cnt=1.
//             Else if repeat_en=0 -> cnt held at 0.
//             Else if cnt==REPEAT_DELAY-1 -> REPEAT, cnt=0, pulse_out=1.
//             Else cnt++.
//   REPEAT:   same rules as HOLD, with REPEAT_PERIOD in place of REPEAT_DELAY; stays in REPEAT on each tick.
//   REL_DB:   pressed_s=1 -> HOLD, cnt=0 (release bounce rejected; repeat timing restarts from REPEAT_DELAY; no pulse).
//             Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE, cnt=0, btn_level=0.
//             Else cnt++.
// - btn_level is 1 in HOLD, REPEAT and REL_DB.
// - pulse_out is never high on 2 consecutive cycles.
// - Release priority: a release seen in the same cycle a repeat tick would fire wins; no pulse is emitted.
// - Press latency: btn_n low sampled at edge E0 -> pulse_out high after edge E(DEBOUNCE_CYCLES+1), for exactly 1 cycle.
//   Release latency to btn_level=0 is the same.
// - repeat_en is sampled every cycle. Deasserting it in REPEAT stops ticks but keeps the state.
//   Re-asserting it resumes timing from cnt=0 in the current state.
// - After reset with the button still held: the synchronizer starts released, so the held button is re-accepted
//   as a new press after the debounce.
// TESTING (bench params DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; t = edges after btn_n change)
// 1. btn_n low 30 cycles, repeat_en=0
//    -> single pulse at t=5, btn_level 1 from t=5.
//    Then btn_n high -> btn_level 0 at t=5 after release; no further pulses.
// 2. btn_n pattern (low 3, high 1) x6, then high
//    -> pulse_out never asserts; btn_level stays 0.
// 3. btn_n low 40 cycles, repeat_en=1
//    -> pulses at t=5, 15, 18, 21, 24, ...
//    Each pulse is 1 cycle wide; no pulse after release is debounced.
// 4. Held in HOLD, then btn_n high 2 cycles, then low again
//    -> no pulse; btn_level stays 1; the next repeat pulse comes 10 cycles after returning to HOLD.
// 5. reset_fixed low for 3 cycles while in REPEAT with btn_n held low
//    -> pulse_out=0 and btn_level=0 immediately.
//    After reset release -> a new press pulse appears 5 edges later.
// 6. In REPEAT, repeat_en=0 for 10 cycles, then 1
//    -> no pulses while 0; the next pulse comes 3 cycles after re-enable.
//    btn_level stays 1 throughout.

Source files
------------

// File: rtl/button_pulse_gen.sv
// Pushbutton front end: synchronizes and debounces an active-low button and emits
// one single-cycle pulse per accepted press, plus optional auto-repeat pulses while held.
module button_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk,
  input  logic reset_fixed,
  input  logic btn_n,
  input  logic repeat_en,
  output logic pulse_out,
  output logic btn_level
);

  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CW      = $clog2(MAX_ALL) + 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HOLD     = 3'd2,
    REPEAT   = 3'd3,
    REL_DB   = 3'd4
  } state_t;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          pressed_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          level_q, level_d;
  logic [CW-1:0] tick_last;

  // Synchronizer flops reset to "released" so a held button is re-debounced after reset.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
  end

  assign pressed_s = ~sync2_q;
  assign tick_last = (state_q == HOLD) ? RD_LAST : RP_LAST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed_s) begin
          state_d = PRESS_DB;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_DB: begin
        if (!pressed_s) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d = HOLD;
          cnt_d   = CNT_ZERO;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HOLD, REPEAT: begin
        // Release is checked first so it beats a coincident repeat tick.
        if (!pressed_s) begin
          state_d = REL_DB;
          cnt_d   = CNT_ONE;
        end else if (!repeat_en) begin
          cnt_d = CNT_ZERO;
        end else if (cnt_q == tick_last) begin
          state_d = REPEAT;
          cnt_d   = CNT_ZERO;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      REL_DB: begin
        if (pressed_s) begin
          state_d = HOLD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
    level_d = (state_d == HOLD) || (state_d == REPEAT) || (state_d == REL_DB);
  end

  always_ff @(posedge clk or negedge reset_fixed) begin
    if (!reset_fixed) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign pulse_out = pulse_q;
  assign btn_level = level_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Bench for button_pulse_gen: directed scenarios plus random button activity,
// all compared against a run-length / elapsed-time reference model.
module tb_button_pulse_gen;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic clk = 1'b0;
  logic reset_fixed = 1'b0;
  logic btn_n = 1'b1;
  logic repeat_en = 1'b0;
  wire  pulse_out;
  wire  btn_level;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_pulse_gen #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .reset_fixed(reset_fixed),
    .btn_n      (btn_n),
    .repeat_en  (repeat_en),
    .pulse_out  (pulse_out),
    .btn_level  (btn_level)
  );

  // Reference model: the button is seen two samples late; the debounced level flips
  // after DB consecutive opposing samples; repeat ticks fire when the elapsed time
  // since the last timing reference equals the current period.
  bit dl[$];
  int run;
  int ref_cyc;
  int period;
  int cyc;
  bit m_level;
  bit m_pulse;

  task automatic model_reset();
    dl = {1'b1, 1'b1};
    run = 0;
    ref_cyc = 0;
    period = RD;
    m_level = 1'b0;
    m_pulse = 1'b0;
  endtask

  task automatic step();
    bit pressed;
    @(posedge clk);
    if (!reset_fixed) begin
      model_reset();
    end else begin
      pressed = ~dl.pop_front();
      dl.push_back(btn_n);
      m_pulse = 1'b0;
      if (!m_level) begin
        run = pressed ? run + 1 : 0;
        if (run == DB) begin
          m_level = 1'b1; m_pulse = 1'b1; run = 0; ref_cyc = cyc; period = RD;
        end
      end else if (!pressed) begin
        run++;
        if (run == DB) begin
          m_level = 1'b0; run = 0;
        end
      end else if (run > 0) begin
        run = 0; ref_cyc = cyc; period = RD;
      end else if (!repeat_en) begin
        ref_cyc = cyc;
      end else if (cyc - ref_cyc == period) begin
        m_pulse = 1'b1; ref_cyc = cyc; period = RP;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    reset_fixed = 1'b0;
    btn_n = 1'b1;
    repeat_en = 1'b0;
    step();
    step();
    checks++;
    if ({pulse_out, btn_level} !== 2'b00) begin
      errors++;
      $display("FAIL reset_state pulse_out/btn_level=%b%b required=00", pulse_out, btn_level);
    end
    reset_fixed = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({pulse_out, btn_level} !== {m_pulse, m_level}) begin
        errors++;
        $display("FAIL reset_idle i=%0d got=%b%b required=%b%b", i, pulse_out, btn_level, m_pulse, m_level);
      end
    end
  endtask

  task automatic test_single_press();
    int npulse = 0;
    int first_pulse = -1;
    int level_fall = -1;
    repeat_en = 1'b0;
    btn_n = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (i == 30) btn_n = 1'b1;
      step();
      checks++;
      if ({pulse_out, btn_level} !== {m_pulse, m_level}) begin
        errors++;
        $display("FAIL single_press i=%0d got=%b%b required=%b%b", i, pulse_out, btn_level, m_pulse, m_level);
      end
      if (pulse_out === 1'b1) begin
        npulse++;
        if (first_pulse < 0) first_pulse = i;
      end
      if (i >= 30 && btn_level === 1'b0 && level_fall < 0) level_fall = i;
    end
    checks++;
    if (npulse !== 1 || first_pulse !== 5) begin
      errors++;
      $display("FAIL single_press_count pulses=%0d at=%0d required=1 at=5", npulse, first_pulse);
    end
    checks++;
    if (level_fall !== 35) begin
      errors++;
      $display("FAIL release_latency fall_at=%0d required=35", level_fall);
    end
  endtask

  task automatic test_bounce();
    int npulse = 0;
    int nlevel = 0;
    repeat_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      btn_n = (i < 24) ? ((i % 4) == 3) : 1'b1;
      step();
      checks++;
      if ({pulse_out, btn_level} !== {m_pulse, m_level}) begin
        errors++;
        $display("FAIL bounce i=%0d got=%b%b required=%b%b", i, pulse_out, btn_level, m_pulse, m_level);
      end
      if (pulse_out === 1'b1) npulse++;
      if (btn_level === 1'b1) nlevel++;
    end
    checks++;
    if (npulse !== 0 || nlevel !== 0) begin
      errors++;
      $display("FAIL bounce_reject pulses=%0d level_cycles=%0d required=0 0", npulse, nlevel);
    end
  endtask

  task automatic test_repeat();
    int npulse = 0;
    int idx[$];
    bit prev = 1'b0;
    int dbl = 0;
    repeat_en = 1'b1;
    btn_n = 1'b0;
    for (int i = 0; i < 55; i++) begin
      if (i == 40) btn_n = 1'b1;
      step();
      checks++;
      if ({pulse_out, btn_level} !== {m_pulse, m_level}) begin
        errors++;
        $display("FAIL repeat i=%0d got=%b%b required=%b%b", i, pulse_out, btn_level, m_pulse, m_level);
      end
      if (pulse_out === 1'b1) begin
        npulse++;
        idx.push_back(i);
        if (prev) dbl++;
      end
      prev = (pulse_out === 1'b1);
    end
    // Tick due at edge 42 coincides with the release being seen, so it is suppressed.
    checks++;
    if (npulse !== 10 || dbl !== 0 || idx[0] !== 5 || idx[1] !== 15 || idx[2] !== 18) begin
      errors++;
      $display("FAIL repeat_schedule pulses=%0d double=%0d first3=%0d,%0d,%0d required=10 0 5,15,18",
               npulse, dbl, idx[0], idx[1], idx[2]);
    end
  endtask

  task automatic test_release_bounce();
    int next_pulse = -1;
    int nlow = 0;
    repeat_en = 1'b1;
    btn_n = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (i == 8) btn_n = 1'b1;
      if (i == 10) btn_n = 1'b0;
      if (i == 35) btn_n = 1'b1;
      step();
      checks++;
      if ({pulse_out, btn_level} !== {m_pulse, m_level}) begin
        errors++;
        $display("FAIL release_bounce i=%0d got=%b%b required=%b%b", i, pulse_out, btn_level, m_pulse, m_level);
      end
      if (i > 5 && pulse_out === 1'b1 && next_pulse < 0) next_pulse = i;
      if (i >= 5 && i < 35 && btn_level !== 1'b1) nlow++;
    end
    checks++;
    if (next_pulse !== 22 || nlow !== 0) begin
      errors++;
      $display("FAIL release_bounce_timing next_pulse=%0d level_drops=%0d required=22 0", next_pulse, nlow);
    end
  endtask

  task automatic test_async_reset();
    int first_pulse = -1;
    repeat_en = 1'b1;
    btn_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({pulse_out, btn_level} !== {m_pulse, m_level}) begin
        errors++;
        $display("FAIL pre_reset i=%0d got=%b%b required=%b%b", i, pulse_out, btn_level, m_pulse, m_level);
      end
    end
    #2;
    reset_fixed = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({pulse_out, btn_level} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset got=%b%b required=00", pulse_out, btn_level);
    end
    step();
    step();
    step();
    reset_fixed = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({pulse_out, btn_level} !== {m_pulse, m_level}) begin
        errors++;
        $display("FAIL post_reset i=%0d got=%b%b required=%b%b", i, pulse_out, btn_level, m_pulse, m_level);
      end
      if (pulse_out === 1'b1 && first_pulse < 0) first_pulse = i;
    end
    checks++;
    if (first_pulse !== 5) begin
      errors++;
      $display("FAIL repress_after_reset pulse_at=%0d required=5", first_pulse);
    end
    btn_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_repeat_gate();
    int gated = 0;
    int resume = -1;
    int nlow = 0;
    btn_n = 1'b0;
    for (int i = 0; i < 55; i++) begin
      repeat_en = !(i >= 25 && i < 35);
      if (i == 45) btn_n = 1'b1;
      step();
      checks++;
      if ({pulse_out, btn_level} !== {m_pulse, m_level}) begin
        errors++;
        $display("FAIL repeat_gate i=%0d got=%b%b required=%b%b", i, pulse_out, btn_level, m_pulse, m_level);
      end
      if (i >= 25 && i < 35 && pulse_out === 1'b1) gated++;
      if (i >= 35 && pulse_out === 1'b1 && resume < 0) resume = i;
      if (i >= 5 && i < 45 && btn_level !== 1'b1) nlow++;
    end
    checks++;
    if (gated !== 0 || resume !== 37 || nlow !== 0) begin
      errors++;
      $display("FAIL repeat_gate_timing gated=%0d resume=%0d drops=%0d required=0 37 0", gated, resume, nlow);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        btn_n = $urandom_range(0, 1);
        hold = (($urandom_range(0, 3)) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
      end
      hold--;
      if ($urandom_range(0, 15) == 0) repeat_en = ~repeat_en;
      step();
      checks++;
      if ({pulse_out, btn_level} !== {m_pulse, m_level}) begin
        errors++;
        $display("FAIL random i=%0d got=%b%b required=%b%b", i, pulse_out, btn_level, m_pulse, m_level);
      end
    end
  endtask

  initial begin
    cyc = 0;
    model_reset();
    test_reset();
    test_single_press();
    test_bounce();
    test_repeat();
    test_release_bounce();
    test_async_reset();
    test_repeat_gate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
